trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_trap_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
//
// Purpose:
//    Trap sequencer for the commit stage. An exception or a return-from-trap
//    in the committing instruction starts a fixed sequence:
//    1. Flush the backend for a minimum number of cycles.
//    2. Wait for the backend to drain.
//    3. Present a redirect to fetch until fetch accepts it.
//    The sequencer records the exception PC and cause so that a later
//    return-from-trap can jump back.
//
// Port summary:
//    clk               single clock
//    reset_            synchronous, active-low reset
//    commit_exp_       active-low: committing instruction raised an exception
//    commit_exp_code   exception code of the committing instruction
//    commit_pc         PC of the committing instruction
//    commit_mret_      active-low: committing instruction is a return-from-trap
//    exp_handler_pc    handler target, valid while commit_exp_ is low
//    backend_empty     high once every in-flight backend instruction is squashed
//    fetch_ready       high when fetch accepts a redirect this cycle
//    exp_flush_        active-low backend flush
//    fetch_redirect_   active-low redirect valid
//    fetch_redirect_pc redirect target
//    trap_busy_        active-low: commit stage must not retire
//    epc               saved exception PC
//    cause             saved exception code
// ---------------------------------------------------------------------------

`ifndef AddrWidth
`define AddrWidth 32
`endif

package trap_pkg;

   // Exception codes. All-zero means "no exception".
   typedef enum logic [3:0] {
      EXP_NONE           = 4'd0,
      EXP_INSTR_MISALIGN = 4'd1,
      EXP_INSTR_FAULT    = 4'd2,
      EXP_ILLEGAL        = 4'd3,
      EXP_BREAK          = 4'd4,
      EXP_LOAD_FAULT     = 4'd5,
      EXP_STORE_FAULT    = 4'd6,
      EXP_ECALL          = 4'd7
   } ExpCode_t;

endpackage

module trap_ctrl
   import trap_pkg::*;
#(
   parameter int ADDR      = `AddrWidth,
   parameter int FLUSH_CYC = 2
) (
   input  logic            clk,
   input  logic            reset_,
   input  logic            commit_exp_,
   input  ExpCode_t        commit_exp_code,
   input  logic [ADDR-1:0] commit_pc,
   input  logic            commit_mret_,
   input  logic [ADDR-1:0] exp_handler_pc,
   input  logic            backend_empty,
   input  logic            fetch_ready,
   output logic            exp_flush_,
   output logic            fetch_redirect_,
   output logic [ADDR-1:0] fetch_redirect_pc,
   output logic            trap_busy_,
   output logic [ADDR-1:0] epc,
   output ExpCode_t        cause
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLUSH    = 2'd1,
      DRAIN    = 2'd2,
      REDIRECT = 2'd3
   } State_t;

   // The counter is loaded with FLUSH_CYC-1 on entry to FLUSH. FLUSH is left
   // on the edge where the counter reads zero. That gives exactly FLUSH_CYC
   // cycles in FLUSH.
   localparam logic [3:0] FlushLoad = 4'(FLUSH_CYC - 1);

   State_t          state_q,  state_d;
   logic [3:0]      cnt_q,    cnt_d;
   logic [ADDR-1:0] epc_q,    epc_d;
   ExpCode_t        cause_q,  cause_d;
   logic [ADDR-1:0] target_q, target_d;
   logic            flush_q,  flush_d;
   logic            busy_q,   busy_d;
   logic            redir_q,  redir_d;

   // Next-state and next-output logic.
   // Each output is computed together with the state it belongs to. When it
   // is registered, it changes on the same edge as the state. For example,
   // flush and busy drop on the edge that enters FLUSH and rise on the edge
   // that leaves REDIRECT.
   // Commit requests are only looked at in IDLE. Because REDIRECT always
   // returns to IDLE first, a commit presented during the return cycle is
   // never sampled.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      epc_d    = epc_q;
      cause_d  = cause_q;
      target_d = target_q;
      flush_d  = flush_q;
      busy_d   = busy_q;
      redir_d  = redir_q;

      case (state_q)
         IDLE: begin
            if (!commit_exp_) begin
               // The exception wins over a simultaneous return-from-trap.
               epc_d    = commit_pc;
               cause_d  = commit_exp_code;
               target_d = exp_handler_pc;
               cnt_d    = FlushLoad;
               flush_d  = 1'b0;
               busy_d   = 1'b0;
               state_d  = FLUSH;
            end else if (!commit_mret_) begin
               // Return-from-trap jumps back to the saved PC.
               // The saved PC and cause are left unchanged.
               target_d = epc_q;
               cnt_d    = FlushLoad;
               flush_d  = 1'b0;
               busy_d   = 1'b0;
               state_d  = FLUSH;
            end
         end

         FLUSH: begin
            if (cnt_q == 4'd0) begin
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         DRAIN: begin
            if (backend_empty) begin
               redir_d = 1'b0;
               state_d = REDIRECT;
            end
         end

         REDIRECT: begin
            if (fetch_ready) begin
               redir_d = 1'b1;
               flush_d = 1'b1;
               busy_d  = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   // Reset aborts any trap in progress and returns every output to idle.
   // The redirect output drops at once, so no redirect can follow.
   always_ff @(posedge clk) begin
      if (!reset_) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         epc_q    <= '0;
         cause_q  <= EXP_NONE;
         target_q <= '0;
         flush_q  <= 1'b1;
         busy_q   <= 1'b1;
         redir_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         epc_q    <= epc_d;
         cause_q  <= cause_d;
         target_q <= target_d;
         flush_q  <= flush_d;
         busy_q   <= busy_d;
         redir_q  <= redir_d;
      end
   end

   assign exp_flush_        = flush_q;
   assign trap_busy_        = busy_q;
   assign fetch_redirect_   = redir_q;
   assign fetch_redirect_pc = target_q;
   assign epc               = epc_q;
   assign cause             = cause_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl
//
// Directed bench for trap_ctrl. Each task covers one scenario:
//    - reset
//    - exception
//    - return-from-trap
//    - exception/return priority
//    - stalled drain and redirect
//    - reset in the middle of a trap
// Inputs change and outputs are sampled on the falling clock edge. Cycle k
// is the period after the k-th rising edge counted from the commit cycle.
// ---------------------------------------------------------------------------

module tb_trap_ctrl;
   import trap_pkg::*;

   localparam int ADDR = 32;
   localparam int FLUSH_CYC = 2;

   logic            clk = 1'b0;
   logic            reset_;
   logic            commit_exp_;
   ExpCode_t        commit_exp_code;
   logic [ADDR-1:0] commit_pc;
   logic            commit_mret_;
   logic [ADDR-1:0] exp_handler_pc;
   logic            backend_empty;
   logic            fetch_ready;
   logic            exp_flush_;
   logic            fetch_redirect_;
   logic [ADDR-1:0] fetch_redirect_pc;
   logic            trap_busy_;
   logic [ADDR-1:0] epc;
   ExpCode_t        cause;

   int nChecks = 0;
   int nFails  = 0;

   trap_ctrl #(.ADDR(ADDR), .FLUSH_CYC(FLUSH_CYC)) dut (
      .clk               (clk),
      .reset_            (reset_),
      .commit_exp_       (commit_exp_),
      .commit_exp_code   (commit_exp_code),
      .commit_pc         (commit_pc),
      .commit_mret_      (commit_mret_),
      .exp_handler_pc    (exp_handler_pc),
      .backend_empty     (backend_empty),
      .fetch_ready       (fetch_ready),
      .exp_flush_        (exp_flush_),
      .fetch_redirect_   (fetch_redirect_),
      .fetch_redirect_pc (fetch_redirect_pc),
      .trap_busy_        (trap_busy_),
      .epc               (epc),
      .cause             (cause)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Hard time limit so the bench always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one cycle and land on the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_          = 1'b0;
      commit_exp_     = 1'b1;
      commit_mret_    = 1'b1;
      commit_exp_code = EXP_NONE;
      commit_pc       = '0;
      exp_handler_pc  = '0;
      backend_empty   = 1'b1;
      fetch_ready     = 1'b1;
      step();
      step();
      // A commit during reset must not start anything
      commit_exp_ = 1'b0;
      commit_pc   = 32'h0000_0ABC;
      step();
      nChecks++; if (exp_flush_ !== 1'b1) begin nFails++; $display("[TB] FAIL reset_flush: got %b want 1", exp_flush_); end
      nChecks++; if (trap_busy_ !== 1'b1) begin nFails++; $display("[TB] FAIL reset_busy: got %b want 1", trap_busy_); end
      nChecks++; if (fetch_redirect_ !== 1'b1) begin nFails++; $display("[TB] FAIL reset_redir: got %b want 1", fetch_redirect_); end
      nChecks++; if (fetch_redirect_pc !== 32'h0) begin nFails++; $display("[TB] FAIL reset_pc: got %h want 0", fetch_redirect_pc); end
      nChecks++; if (epc !== 32'h0) begin nFails++; $display("[TB] FAIL reset_epc: got %h want 0", epc); end
      nChecks++; if (cause !== EXP_NONE) begin nFails++; $display("[TB] FAIL reset_cause: got %0d want 0", cause); end
      commit_exp_ = 1'b1;
      commit_pc   = '0;
      reset_      = 1'b1;
      step();
      nChecks++; if (exp_flush_ !== 1'b1) begin nFails++; $display("[TB] FAIL post_reset_flush: got %b want 1", exp_flush_); end
   endtask

   // Common walk through cycles 1..5 of an unstalled trap.
   // Flush and busy are low in cycles 1..4, the redirect appears in cycle 4,
   // and the sequencer is back in idle in cycle 5.
   task automatic walk_trap(input string name, input logic [ADDR-1:0] expPc,
                            input logic [ADDR-1:0] expEpc, input ExpCode_t expCause);
      for (int cyc = 1; cyc <= 5; cyc++) begin
         logic expLow;
         expLow = (cyc <= 4) ? 1'b0 : 1'b1;
         nChecks++; if (exp_flush_ !== expLow) begin nFails++; $display("[TB] FAIL %s_flush c%0d: got %b want %b", name, cyc, exp_flush_, expLow); end
         nChecks++; if (trap_busy_ !== expLow) begin nFails++; $display("[TB] FAIL %s_busy c%0d: got %b want %b", name, cyc, trap_busy_, expLow); end
         nChecks++; if (fetch_redirect_ !== (cyc != 4)) begin nFails++; $display("[TB] FAIL %s_redir c%0d: got %b want %b", name, cyc, fetch_redirect_, (cyc != 4)); end
         nChecks++; if (epc !== expEpc) begin nFails++; $display("[TB] FAIL %s_epc c%0d: got %h want %h", name, cyc, epc, expEpc); end
         nChecks++; if (cause !== expCause) begin nFails++; $display("[TB] FAIL %s_cause c%0d: got %0d want %0d", name, cyc, cause, expCause); end
         if (cyc == 4) begin
            nChecks++; if (fetch_redirect_pc !== expPc) begin nFails++; $display("[TB] FAIL %s_pc: got %h want %h", name, fetch_redirect_pc, expPc); end
         end
         step();
      end
   endtask

   task automatic test_exception();
      commit_exp_     = 1'b0;
      commit_exp_code = EXP_BREAK;
      commit_pc       = 32'h0000_1000;
      exp_handler_pc  = 32'h000C_AFE0;
      backend_empty   = 1'b1;
      fetch_ready     = 1'b1;
      step();
      commit_exp_     = 1'b1;
      commit_exp_code = EXP_NONE;
      commit_pc       = '0;
      exp_handler_pc  = '0;
      walk_trap("exc", 32'h000C_AFE0, 32'h0000_1000, EXP_BREAK);
   endtask

   task automatic test_mret();
      commit_mret_   = 1'b0;
      commit_pc      = 32'h0000_5550;
      exp_handler_pc = 32'h0001_2340;
      step();
      commit_mret_   = 1'b1;
      commit_pc      = '0;
      exp_handler_pc = '0;
      walk_trap("mret", 32'h0000_1000, 32'h0000_1000, EXP_BREAK);
   endtask

   task automatic test_priority();
      commit_exp_     = 1'b0;
      commit_mret_    = 1'b0;
      commit_exp_code = EXP_ILLEGAL;
      commit_pc       = 32'h0000_2000;
      exp_handler_pc  = 32'h000A_BC00;
      step();
      commit_exp_     = 1'b1;
      commit_mret_    = 1'b1;
      commit_exp_code = EXP_NONE;
      commit_pc       = '0;
      exp_handler_pc  = '0;
      walk_trap("prio", 32'h000A_BC00, 32'h0000_2000, EXP_ILLEGAL);
   endtask

   // The trap stalls in each wait state.
   // - DRAIN: backend_empty is low for cycles 3..7 and high in cycle 8.
   // - REDIRECT: fetch_ready is low for cycles 9..11 and high in cycle 12.
   // - Idle again from cycle 13.
   // Two extra commits are presented and must both be ignored:
   // - an exception pulse in cycle 5, while in DRAIN;
   // - an exception in cycle 12, the cycle that returns to idle.
   task automatic test_stall();
      commit_exp_     = 1'b0;
      commit_exp_code = EXP_ECALL;
      commit_pc       = 32'h0000_3000;
      exp_handler_pc  = 32'h0004_4440;
      backend_empty   = 1'b0;
      fetch_ready     = 1'b0;
      step();
      for (int cyc = 1; cyc <= 14; cyc++) begin
         logic expLow;
         logic expRedir;
         expLow   = (cyc <= 12) ? 1'b0 : 1'b1;
         expRedir = (cyc >= 9 && cyc <= 12) ? 1'b0 : 1'b1;
         nChecks++; if (exp_flush_ !== expLow) begin nFails++; $display("[TB] FAIL stall_flush c%0d: got %b want %b", cyc, exp_flush_, expLow); end
         nChecks++; if (trap_busy_ !== expLow) begin nFails++; $display("[TB] FAIL stall_busy c%0d: got %b want %b", cyc, trap_busy_, expLow); end
         nChecks++; if (fetch_redirect_ !== expRedir) begin nFails++; $display("[TB] FAIL stall_redir c%0d: got %b want %b", cyc, fetch_redirect_, expRedir); end
         nChecks++; if (fetch_redirect_pc !== 32'h0004_4440) begin nFails++; $display("[TB] FAIL stall_pc c%0d: got %h want 44440", cyc, fetch_redirect_pc); end
         nChecks++; if (epc !== 32'h0000_3000) begin nFails++; $display("[TB] FAIL stall_epc c%0d: got %h want 3000", cyc, epc); end
         nChecks++; if (cause !== EXP_ECALL) begin nFails++; $display("[TB] FAIL stall_cause c%0d: got %0d want %0d", cyc, cause, EXP_ECALL); end
         commit_exp_     = (cyc == 5 || cyc == 12) ? 1'b0 : 1'b1;
         commit_exp_code = (cyc == 5 || cyc == 12) ? EXP_LOAD_FAULT : EXP_NONE;
         commit_pc       = (cyc == 5 || cyc == 12) ? 32'h0000_9990 : 32'h0;
         exp_handler_pc  = (cyc == 5 || cyc == 12) ? 32'h0005_5550 : 32'h0;
         backend_empty   = (cyc >= 8);
         fetch_ready     = (cyc >= 12);
         step();
      end
   endtask

   task automatic test_reset_mid();
      commit_exp_     = 1'b0;
      commit_exp_code = EXP_STORE_FAULT;
      commit_pc       = 32'h0000_6000;
      exp_handler_pc  = 32'h0007_7700;
      backend_empty   = 1'b0;
      fetch_ready     = 1'b1;
      step();
      commit_exp_ = 1'b1;
      step();
      step();
      // Cycle 3: in DRAIN
      nChecks++; if (exp_flush_ !== 1'b0) begin nFails++; $display("[TB] FAIL rmid_flush_pre: got %b want 0", exp_flush_); end
      reset_ = 1'b0;
      step();
      nChecks++; if (exp_flush_ !== 1'b1) begin nFails++; $display("[TB] FAIL rmid_flush: got %b want 1", exp_flush_); end
      nChecks++; if (trap_busy_ !== 1'b1) begin nFails++; $display("[TB] FAIL rmid_busy: got %b want 1", trap_busy_); end
      nChecks++; if (fetch_redirect_ !== 1'b1) begin nFails++; $display("[TB] FAIL rmid_redir: got %b want 1", fetch_redirect_); end
      nChecks++; if (fetch_redirect_pc !== 32'h0) begin nFails++; $display("[TB] FAIL rmid_pc: got %h want 0", fetch_redirect_pc); end
      nChecks++; if (epc !== 32'h0) begin nFails++; $display("[TB] FAIL rmid_epc: got %h want 0", epc); end
      nChecks++; if (cause !== EXP_NONE) begin nFails++; $display("[TB] FAIL rmid_cause: got %0d want 0", cause); end
      reset_        = 1'b1;
      backend_empty = 1'b1;
      for (int cyc = 0; cyc < 6; cyc++) begin
         step();
         nChecks++; if (fetch_redirect_ !== 1'b1) begin nFails++; $display("[TB] FAIL rmid_no_redir c%0d: got %b want 1", cyc, fetch_redirect_); end
         nChecks++; if (exp_flush_ !== 1'b1) begin nFails++; $display("[TB] FAIL rmid_idle_flush c%0d: got %b want 1", cyc, exp_flush_); end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_exception();
      test_mret();
      test_priority();
      test_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
